// File: rtl/ttl_74502_pkg.sv
// Shared types and defaults for the ttl_74502 successive-approximation register.
package ttl_74502_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        DONE
    } state_t;

endpackage

// File: rtl/ttl_74502.sv
// Successive-approximation register: MSB-first binary search driven by an external comparator.
// Optional serial bit output is enabled by defining TTL_74502_SERIAL_OUT_EN.
module ttl_74502
    import ttl_74502_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int DELAY_RISE = 0,
    parameter int DELAY_FALL = 0
) (
    input  logic             Clk,
    input  logic             Clear,
    input  logic             Start,
    input  logic             Compare_in,
    output logic [WIDTH-1:0] Q,
    output logic             Done
`ifdef TTL_74502_SERIAL_OUT_EN
    ,
    output logic             Serial_out
`endif
);

    localparam int PW = $clog2(WIDTH);
    localparam logic [PW-1:0] PTR_MSB = PW'(WIDTH - 1);

    state_t           state;
    logic [PW-1:0]    ptr;
    logic [WIDTH-1:0] q_r;
    logic             done_r;
`ifdef TTL_74502_SERIAL_OUT_EN
    logic             ser_r;
`endif

    // Start has priority over every state, so a restart mid-conversion never flags a partial result.
    always_ff @(posedge Clk or posedge Clear) begin
        if (Clear) begin
            state  <= IDLE;
            ptr    <= PTR_MSB;
            q_r    <= '0;
            done_r <= 1'b0;
`ifdef TTL_74502_SERIAL_OUT_EN
            ser_r  <= 1'b0;
`endif
        end else if (Start) begin
            state  <= CONVERT;
            ptr    <= PTR_MSB;
            q_r    <= {1'b1, {(WIDTH-1){1'b0}}};
            done_r <= 1'b0;
`ifdef TTL_74502_SERIAL_OUT_EN
            ser_r  <= 1'b0;
`endif
        end else if (state == CONVERT) begin
            q_r[ptr] <= Compare_in;
`ifdef TTL_74502_SERIAL_OUT_EN
            ser_r    <= Compare_in;
`endif
            if (ptr != '0) begin
                q_r[ptr - 1'b1] <= 1'b1;
                ptr             <= ptr - 1'b1;
            end else begin
                done_r <= 1'b1;
                state  <= DONE;
            end
        end
    end

    assign #(DELAY_RISE, DELAY_FALL) Q    = q_r;
    assign #(DELAY_RISE, DELAY_FALL) Done = done_r;
`ifdef TTL_74502_SERIAL_OUT_EN
    assign #(DELAY_RISE, DELAY_FALL) Serial_out = ser_r;
`endif

endmodule

// File: doc/ttl_74502.md
TTL_74502 -- requirements
Module: ttl_74502

Interface
REQ-001 Parameter: WIDTH, default 8, register width in bits (minimum 2).
REQ-002 Parameter: DELAY_RISE, default 0, output rise delay in time units.
REQ-003 Parameter: DELAY_FALL, default 0, output fall delay in time units.
REQ-004 Clk  input  1  single clock; all state changes occur on the rising edge.
REQ-005 Clear  input  1  reset, asynchronous and active-high.
REQ-006 Start  input  1  sampled at a rising Clk edge; high begins a new conversion.
REQ-007 Compare_in  input  1  comparator decision: 1 keeps the trial bit (input not less than Q), 0 drops it.
REQ-008 Q  output  WIDTH  successive-approximation register value.
REQ-009 Done  output  1  conversion complete; high while Q holds a final result.
REQ-010 Serial_out  output  1  bit decided on the most recent edge, MSB first (macro-dependent, see REQ-026/027).

Function
REQ-011 The block SHALL implement three states: IDLE, CONVERT and DONE.
REQ-012 In any state, a Start=1 sample SHALL load Q={1'b1, (WIDTH-1){1'b0}}, set the bit pointer to WIDTH-1, clear Done and enter CONVERT.
REQ-013 In CONVERT with Start=0, each edge SHALL write Q[ptr]<=Compare_in and, if ptr>0, set Q[ptr-1]<=1 and decrement ptr.
REQ-014 In CONVERT with ptr==0, the edge SHALL write Q[0]<=Compare_in, set Done=1 and enter DONE.
REQ-015 Latency SHALL be exactly WIDTH+1 rising edges from the Start sample to Done=1.
REQ-016 DONE SHALL hold Q and Done=1 unchanged until the next Start or Clear.
REQ-017 IDLE with Start=0 SHALL hold all outputs.
REQ-018 Start=1 during CONVERT SHALL abort and restart per REQ-012, with no partial result flagged.
REQ-019 Serial_out SHALL equal the Compare_in value written on the most recent CONVERT edge, and 0 after a Start load.
REQ-020 Bits below ptr SHALL remain 0 during conversion, and bits above ptr SHALL hold their decided values.
REQ-021 All outputs SHALL be driven through continuous assigns with #(DELAY_RISE, DELAY_FALL).
REQ-022 An X on Compare_in SHALL propagate to the decided Q bit, with no masking.

Reset
REQ-023 Clear=1 SHALL immediately force Q=0, Done=0, Serial_out=0, ptr=WIDTH-1 and state IDLE, independent of Clk.
REQ-024 Clear asserted mid-conversion SHALL discard the partial result, and no Done pulse SHALL follow.
REQ-025 While Clear=1, Start SHALL be ignored; the first edge after release with Start=1 SHALL begin a conversion.

Configuration
REQ-026 With macro TTL_74502_SERIAL_OUT_EN defined, the Serial_out port and its logic SHALL be present per REQ-019.
REQ-027 Without TTL_74502_SERIAL_OUT_EN, the Serial_out port SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-028 A shared package SHALL hold the state enumeration (IDLE/CONVERT/DONE) and the default WIDTH constant.
REQ-029 No sub-module SHALL be used; the pointer/state logic is a single always block plus output assigns.

Verification
REQ-030 WIDTH=8, a bench model drives Compare_in=(8'hA5>=Q), Start pulse -> after 9 edges Q=8'hA5 and Done=1, with Done=0 on edges 1-8.
REQ-031 Same model, target 8'h00 -> Q=8'h00; target 8'hFF -> Q=8'hFF; each with Done=1 at edge 9.
REQ-032 Target 8'hA5, SERIAL_OUT_EN defined -> Serial_out sequence 1,0,1,0,0,1,0,1 on edges 2-9.
REQ-033 Start re-asserted at edge 4 with target changed to 8'h3C -> Q=8'h3C and Done=1 exactly 9 edges after the second Start.
REQ-034 Clear pulsed between edges 5 and 6 -> Q=0, Done=0 immediately, and Done stays 0 until a new Start plus 9 edges.
REQ-035 With DELAY_RISE=5 and DELAY_FALL=3, Done rise is sampled X/0 at +2 and 1 at +6 after the final edge.
